// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Holds the FSM state encoding, BCD digit limits and the load-value check.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_FIELD_W = 8;
  localparam int ONES_MAX    = 9;
  localparam int TENS_MAX    = 5;

  // The top field may allow a wider tens range than the base-60 fields below it.
  function automatic logic bcd_field_valid(input logic [7:0] value,
                                           input logic       is_top,
                                           input logic [3:0] top_tens_max);
    logic [3:0] tens_lim;
    tens_lim = is_top ? top_tens_max : 4'(TENS_MAX);
    return (value[3:0] <= 4'(ONES_MAX)) && (value[7:4] <= tens_lim);
  endfunction

endpackage

// File: rtl/bcd_field_dec.sv
// One 8-bit BCD field with load and borrow-driven decrement; registered, 1-clk update.
// Priority clr > ld > borrow_in; borrow_out is combinational so a whole chain settles in one clk.
module bcd_field_dec
  import bcd_timer_pkg::*;
#(
  parameter int TENS_WRAP = TENS_MAX
) (
  input  logic                   clk,
  input  logic                   R,
  input  logic                   clr,
  input  logic                   ld,
  input  logic [BCD_FIELD_W-1:0] ld_val,
  input  logic                   borrow_in,
  output logic [BCD_FIELD_W-1:0] q,
  output logic                   borrow_out,
  output logic                   is_zero
);

  assign is_zero    = (q == '0);
  assign borrow_out = borrow_in & is_zero;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (borrow_in) begin
      if (q[3:0] != 4'd0) begin
        q[3:0] <= q[3:0] - 4'd1;
      end else begin
        q[3:0] <= 4'(ONES_MAX);
        q[7:4] <= (q[7:4] == 4'd0) ? 4'(TENS_WRAP) : q[7:4] - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-field BCD countdown timer with start/stop/pause, validated per-field load and done/end pulse.
// Optional periodic reload when BCD_COUNTDOWN_AUTO_RELOAD_EN is defined; all outputs registered.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int N_FIELDS     = 2,
  parameter int TOP_TENS_MAX = 5
) (
  input  logic                            clk,
  input  logic                            R,
  input  logic                            ce,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            clear,
  input  logic                            load,
  input  logic [1:0]                      sel,
  input  logic [7:0]                      DI,
  output logic [BCD_FIELD_W*N_FIELDS-1:0] Q,
  output logic                            running,
  output logic                            done,
  output logic                            end_pulse,
  output logic                            load_err
);

  state_t state_q, state_d;

  logic [N_FIELDS-1:0][BCD_FIELD_W-1:0] q_f, ld_val;
  logic [N_FIELDS-1:0]                  ld, ld_user, fz, bout;
  logic [N_FIELDS:0]                    borrow;
  logic clr, dec, end_d, err_d, do_load, load_ok, q_zero, q_one, reload;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [N_FIELDS-1:0][BCD_FIELD_W-1:0] preset_q;
  logic                                 preset_zero;
  assign preset_zero = (preset_q == '0);
`endif

  assign Q      = q_f;
  assign q_zero = &fz;
  assign q_one  = (Q == (BCD_FIELD_W*N_FIELDS)'(1));
  assign err_d  = do_load & ~load_ok;

  always_comb begin
    load_ok = 1'b0;
    for (int i = 0; i < N_FIELDS; i++) begin
      if (int'(sel) == i) load_ok = bcd_field_valid(DI, i == N_FIELDS - 1, 4'(TOP_TENS_MAX));
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    dec     = 1'b0;
    end_d   = 1'b0;
    do_load = 1'b0;
    reload  = 1'b0;
    if (clear) begin
      clr     = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (!stop) begin
            if (start) begin
              if (!q_zero) state_d = RUN;
            end else if (load) begin
              do_load = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (ce) begin
            dec = 1'b1;
            if (q_one) begin
              end_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
              if (!preset_zero) reload = 1'b1;
              else              state_d = DONE;
`else
              state_d = DONE;
`endif
            end
          end
        end
        DONE: begin
          if (!stop && load) begin
            do_load = 1'b1;
            if (load_ok) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reload overrides the decrement because field load wins over borrow_in.
  always_comb begin
    ld_user = '0;
    for (int i = 0; i < N_FIELDS; i++) begin
      ld_val[i] = DI;
      if (do_load && load_ok && int'(sel) == i) ld_user[i] = 1'b1;
    end
    ld = ld_user;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    if (reload) begin
      ld     = '1;
      ld_val = preset_q;
    end
`endif
  end

  assign borrow[0] = dec;

  // A borrow out of the top field would wrap the count; pin it at zero instead.
  for (genvar i = 0; i < N_FIELDS; i++) begin : g_field
    bcd_field_dec #(
      .TENS_WRAP((i == N_FIELDS - 1) ? TOP_TENS_MAX : TENS_MAX)
    ) u_field (
      .clk       (clk),
      .R         (R),
      .clr       (clr | borrow[N_FIELDS]),
      .ld        (ld[i]),
      .ld_val    (ld_val[i]),
      .borrow_in (borrow[i]),
      .q         (q_f[i]),
      .borrow_out(bout[i]),
      .is_zero   (fz[i])
    );
    assign borrow[i+1] = bout[i];
  end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      preset_q <= '0;
    end else if (clr) begin
      preset_q <= '0;
    end else begin
      for (int i = 0; i < N_FIELDS; i++) begin
        if (ld_user[i]) preset_q[i] <= DI;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q   <= IDLE;
      running   <= 1'b0;
      done      <= 1'b0;
      end_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running   <= (state_d == RUN);
      done      <= (state_d == DONE);
      end_pulse <= end_d;
      load_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (N_FIELDS=2, TOP_TENS_MAX=5).
// Reload section is compiled only with BCD_COUNTDOWN_AUTO_RELOAD_EN.
module tb_bcd_countdown_timer;

  localparam int S_Q = 0, S_RUN = 1, S_DONE = 2, S_END = 3, S_ERR = 4;

  logic        clk = 1'b0;
  logic        R = 1'b1;
  logic        ce = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [7:0]  DI = 8'd0;
  logic [15:0] Q;
  logic        running, done, end_pulse, load_err;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  int          sig_q[$];
  logic [15:0] val_q[$];

  bcd_countdown_timer #(.N_FIELDS(2), .TOP_TENS_MAX(5)) dut (
    .clk(clk), .R(R), .ce(ce), .start(start), .stop(stop), .clear(clear),
    .load(load), .sel(sel), .DI(DI), .Q(Q), .running(running), .done(done),
    .end_pulse(end_pulse), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic want(input string tag, input int s, input logic [15:0] v);
    tag_q.push_back(tag);
    sig_q.push_back(s);
    val_q.push_back(v);
  endtask

  task automatic drain();
    string       t;
    int          s;
    logic [15:0] v, g;
    while (val_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sig_q.pop_front();
      v = val_q.pop_front();
      case (s)
        S_Q:     g = Q;
        S_RUN:   g = {15'd0, running};
        S_DONE:  g = {15'd0, done};
        S_END:   g = {15'd0, end_pulse};
        default: g = {15'd0, load_err};
      endcase
      chk(t, g, v);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic cl, input logic ld,
                       input logic c, input logic [1:0] s, input logic [7:0] d);
    start = st; stop = sp; clear = cl; load = ld; ce = c; sel = s; DI = d;
  endtask

  task automatic idle();        drive(0, 0, 0, 0, 0, 2'd0, 8'h00); endtask
  task automatic go();          drive(1, 0, 0, 0, 0, 2'd0, 8'h00); endtask
  task automatic tick_ce();     drive(0, 0, 0, 0, 1, 2'd0, 8'h00); endtask
  task automatic clr();         drive(0, 0, 1, 0, 0, 2'd0, 8'h00); endtask
  task automatic ld(input logic [1:0] s, input logic [7:0] d); drive(0, 0, 0, 1, 0, s, d); endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #2;
    want("rst_q", S_Q, 16'h0000);
    want("rst_run", S_RUN, 0);
    want("rst_done", S_DONE, 0);
    want("rst_end", S_END, 0);
    want("rst_err", S_ERR, 0);
    drain();
    @(negedge clk);
    R = 1'b0;

    // 01:00 -> 00:59
    ld(2'd1, 8'h01); want("ld_hi", S_Q, 16'h0100); tick();
    ld(2'd0, 8'h00); want("ld_lo", S_Q, 16'h0100); want("ld_lo_err", S_ERR, 0); tick();
    go();            want("start_run", S_RUN, 1); tick();
    tick_ce();       want("dec_0100", S_Q, 16'h0059); want("dec_run", S_RUN, 1); tick();
    clr();           want("clr_q", S_Q, 16'h0000); want("clr_run", S_RUN, 0); tick();

    // 00:03 counts to zero
    ld(2'd0, 8'h03); want("ld3", S_Q, 16'h0003); tick();
    go();            want("run3", S_RUN, 1); tick();
    tick_ce();       want("c3_q2", S_Q, 16'h0002); want("c3_end0", S_END, 0); tick();
    tick_ce();       want("c3_q1", S_Q, 16'h0001); tick();
    tick_ce();       want("c3_q0", S_Q, 16'h0000); want("c3_end1", S_END, 1);
                     want("c3_done", S_DONE, 1); want("c3_run0", S_RUN, 0); tick();
    idle();          want("end_1clk", S_END, 0); want("done_hold", S_DONE, 1); tick();
    tick_ce();       want("done_ce_q", S_Q, 16'h0000); want("done_ce_d", S_DONE, 1); tick();
    go();            want("done_start", S_DONE, 1); want("done_start_r", S_RUN, 0); tick();
    ld(2'd1, 8'h00); want("done_ld", S_DONE, 0); want("done_ld_q", S_Q, 16'h0000); tick();

    // pause with simultaneous ce, then resume
    ld(2'd0, 8'h10); want("ld10", S_Q, 16'h0010); tick();
    go();            want("run10", S_RUN, 1); tick();
    drive(0, 1, 0, 0, 1, 2'd0, 8'h00);
                     want("stop_ce_q", S_Q, 16'h0010); want("stop_run0", S_RUN, 0); tick();
    for (int i = 0; i < 5; i++) begin
      tick_ce();     want("pause_ce", S_Q, 16'h0010); tick();
    end
    go();            want("resume", S_RUN, 1); want("resume_q", S_Q, 16'h0010); tick();
    tick_ce();       want("resume_dec", S_Q, 16'h0009); tick();
    ld(2'd0, 8'h55); want("run_ld_q", S_Q, 16'h0009); want("run_ld_err", S_ERR, 0);
                     want("run_ld_r", S_RUN, 1); tick();

    // load validation while paused
    drive(0, 1, 0, 0, 0, 2'd0, 8'h00); want("pause2", S_RUN, 0); tick();
    ld(2'd0, 8'h6A); want("bad_6a_err", S_ERR, 1); want("bad_6a_q", S_Q, 16'h0009); tick();
    idle();          want("err_1clk", S_ERR, 0); tick();
    ld(2'd3, 8'h00); want("bad_sel", S_ERR, 1); want("bad_sel_q", S_Q, 16'h0009); tick();
    ld(2'd1, 8'h60); want("bad_top", S_ERR, 1); tick();
    ld(2'd1, 8'h59); want("ok_top", S_Q, 16'h5909); want("ok_top_err", S_ERR, 0); tick();

    // 10:00 -> 09:59
    clr();           tick();
    ld(2'd1, 8'h10); tick();
    ld(2'd0, 8'h00); tick();
    go();            tick();
    tick_ce();       want("dec_1000", S_Q, 16'h0959); tick();

    // asynchronous reset mid-run
    clr();           tick();
    ld(2'd0, 8'h42); tick();
    go();            want("run42", S_RUN, 1); want("run42_q", S_Q, 16'h0042); tick();
    idle();
    #2;
    R = 1'b1;
    #1;
    want("arst_q", S_Q, 16'h0000); want("arst_run", S_RUN, 0);
    drain();
    @(negedge clk);
    @(negedge clk);
    R = 1'b0;
    go();            want("post_rst_run", S_RUN, 0); want("post_rst_q", S_Q, 16'h0000); tick();

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    clr();           tick();
    ld(2'd0, 8'h02); tick();
    go();            tick();
    tick_ce();       want("ar_q1", S_Q, 16'h0001); want("ar_end0", S_END, 0); tick();
    tick_ce();       want("ar_q2", S_Q, 16'h0002); want("ar_end1", S_END, 1); want("ar_run", S_RUN, 1); tick();
    tick_ce();       want("ar_q1b", S_Q, 16'h0001); want("ar_end0b", S_END, 0); tick();
    tick_ce();       want("ar_q2b", S_Q, 16'h0002); want("ar_end1b", S_END, 1); want("ar_runb", S_RUN, 1); tick();
`endif

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised countdown timer that holds N base-60 BCD fields (ss, mm:ss or hh:mm:ss).
- Counts down one unit per ce tick and stops at zero with a done flag and a one-cycle end pulse.
- Sits between the 1 s enable generator and the display multiplexer; replaces hand-chained per-field counters with a single block.
- Adds start/stop/pause control, per-field load with validation, and optional auto-reload.

Parameters:
- N_FIELDS, 2: number of 8-bit BCD fields (1..3); field 0 is least significant.
- TOP_TENS_MAX, 5: maximum tens digit of the top field (5 gives a 0-59 range; 9 gives a 0-99 range).

Ports:
- clk  in  1  system clock
- R  in  1  asynchronous active-high reset
- ce  in  1  count enable tick (one clk wide, e.g. 1 Hz)
- start  in  1  start or resume request (level, sampled each clk)
- stop  in  1  pause request
- clear  in  1  synchronous clear of count and state
- load  in  1  load DI into the field selected by sel
- sel  in  2  field index for load
- DI  in  8  BCD load value {tens[3:0], ones[3:0]}
- Q  out  8*N_FIELDS  current count, BCD, field 0 in Q[7:0]
- running  out  1  high in RUN
- done  out  1  high in DONE
- end_pulse  out  1  one-clk pulse when the count reaches zero
- load_err  out  1  one-clk pulse when a load is rejected

Behaviour:
- Reset (R=1, asynchronous): Q=0, state=IDLE, running=0, done=0, end_pulse=0, load_err=0.
- States are IDLE, RUN, PAUSE and DONE.
- Priority each clk: clear > stop > start > load > ce.
- clear: Q<=0 and state<=IDLE in any state.
- IDLE, start=1:
  - Q!=0: go to RUN next clk.
  - Q==0: stay IDLE and do not assert done.
- RUN:
  - stop=1: go to PAUSE; a ce in the same clk is ignored.
  - ce=1: decrement Q by 1.
  - If the result is 0: go to DONE and end_pulse=1 in the same clk that Q becomes 0.
  - load and start are ignored in RUN; load_err stays 0.
- PAUSE:
  - start=1 and stop=0: go to RUN.
  - ce is ignored.
- DONE:
  - done=1 and Q holds 0.
  - start is ignored.
  - load: apply the load and go to IDLE.
- Load (IDLE/PAUSE/DONE):
  - Valid when ones<=9, tens<=5 for non-top fields, tens<=TOP_TENS_MAX for the top field, and sel<N_FIELDS.
  - Valid load: write the field next clk; other fields are unchanged.
  - Invalid load: no write and load_err=1 for one clk.
- Decrement borrow chain:
  - Each field: ones 0 -> 9 with a borrow to tens.
  - Tens 0 -> 5 (non-top) with a borrow out to the next field.
  - The top field never borrows, because zero is detected first.
  - Example: 01:00 -> 00:59; 10:00 -> 09:59.
- end_pulse and load_err are registered and exactly one clk wide.
- running and done are registered decodes of the state.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- When defined:
  - A preset register captures every valid load.
  - On reaching zero in RUN, Q <= preset in the same clk, end_pulse=1, and the state stays RUN (periodic timer).
  - If the preset is 0, the block goes to DONE as normal.
  - clear also zeroes the preset.
- When undefined: no preset register; the block stops in DONE at zero.

Decomposition:
- Package bcd_timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - constant BCD_FIELD_W=8;
  - constants ONES_MAX=9 and TENS_MAX=5;
  - the function bcd_field_valid(value, is_top).
- Sub-module bcd_field_dec:
  - one 8-bit BCD field with ports borrow_in, borrow_out and is_zero.
  - Instantiated N_FIELDS times in a generate loop; the top instance uses TOP_TENS_MAX.

Test Plan:
- Load sel=1 DI=0x01 and sel=0 DI=0x00, start, then 1 ce -> Q=0x0059, running=1.
- Load 00:03, start, then 3 ce -> Q=0x0000, end_pulse=1 for one clk, done=1; further ce leaves Q=0.
- Run from 00:10, assert stop together with ce -> PAUSE, Q stays 0x0010; 5 ce change nothing; start resumes and the next ce gives 0x0009.
- Load sel=0 DI=0x6A -> load_err=1 for one clk, Q unchanged; load with sel=3 when N_FIELDS=2 -> load_err=1.
- Assert R mid-RUN at 00:42 -> Q=0 and IDLE immediately, without waiting for clk; start after release stays IDLE.
- With BCD_COUNTDOWN_AUTO_RELOAD_EN, load 00:02, start, 4 ce -> end_pulse after ce 2 and ce 4, Q=0x0002 after each, running stays 1.
